display_ocupacion: RTL and testbench

//  Downstream display stage of the parking occupancy system. Consumes the

---
 rtl/display_ocupacion.sv | 229 ++++++++++++++++++++++
 tb/tb_display_ocupacion.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_ocupacion.sv
// -----------------------------------------------------------------------------
// display_ocupacion
//   Display stage of the parking occupancy system. Drives a 4-digit
//   multiplexed common-anode 7-segment display:
//     d0 = occupied spaces (min(count,9))
//     d1 = free spaces (CAPACITY-count, clamped to 0..9)
//     d2 = '-' separator
//     d3 = last event letter: 'E' (entrada) / 'S' (salida), held HOLD_CYC
//          cycles, blank otherwise
//   dp is lit on d0 while the lot is full.
//
//   Optional feature macro: BLINK_FULL_EN
//     defined   -> the whole display blinks (BLINK_DIV cycles per half-period)
//                  while the lot is full
//     undefined -> no blink logic; full is shown only by dp on d0
//
// Ports
//   clk      in   1      system clock
//   rst      in   1      asynchronous reset, active-high
//   count    in   CNT_W  current occupancy
//   ingreso  in   1      1-cycle entry pulse
//   egreso   in   1      1-cycle exit pulse
//   seg      out  7      segments {g,f,e,d,c,b,a}, active-low (registered)
//   an       out  4      digit enables, active-low, an[i] selects d[i] (registered)
//   dp       out  1      decimal point, active-low (registered)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module display_ocupacion #(
  parameter int CNT_W       = 3,
  parameter int CAPACITY    = 7,
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_CYC    = 25000000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count,
  input  logic             ingreso,
  input  logic             egreso,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             dp
);

  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IN   = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low 7-segment pattern for a decimal digit; anything else is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [REF_W-1:0]  r_refresh;
  logic [1:0]        r_idx;
  logic [1:0]        r_state;
  logic [HOLD_W-1:0] r_hold;

  logic [31:0]       w_count32;
  logic [CNT_W:0]    w_free;
  logic [31:0]       w_free32;
  logic [3:0]        w_d0;
  logic [3:0]        w_d1;
  logic              w_full;
  logic              w_blank;
  logic              w_in_only;
  logic              w_out_only;
  logic [6:0]        w_seg_next;
  logic [3:0]        w_an_next;
  logic              w_dp_next;

  assign w_count32  = 32'(count);
  assign w_full     = (w_count32 >= 32'(CAPACITY));
  assign w_in_only  = ingreso & ~egreso;
  assign w_out_only = egreso & ~ingreso;

  // Free spaces in CNT_W+1 bits, forced to 0 when over capacity; digits clamped to 9.
  always_comb begin
    if (w_count32 > 32'(CAPACITY)) begin
      w_free = {(CNT_W+1){1'b0}};
    end else begin
      w_free = (CNT_W+1)'(CAPACITY) - {1'b0, count};
    end
    w_free32 = 32'(w_free);
    if (w_free32 > 32'd9) begin
      w_d1 = 4'd9;
    end else begin
      w_d1 = w_free32[3:0];
    end
    if (w_count32 > 32'd9) begin
      w_d0 = 4'd9;
    end else begin
      w_d0 = w_count32[3:0];
    end
  end

  // Refresh divider and digit-scan index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= {REF_W{1'b0}};
      r_idx     <= 2'd0;
    end else if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
      r_refresh <= {REF_W{1'b0}};
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_refresh <= r_refresh + REF_W'(1);
      r_idx     <= r_idx;
    end
  end

  // Event-letter FSM: a lone pulse (re)loads the hold time from any state;
  // simultaneous pulses are ignored, and a pulse on the expiry cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= {HOLD_W{1'b0}};
    end else if (w_in_only) begin
      r_state <= S_IN;
      r_hold  <= HOLD_W'(HOLD_CYC - 1);
    end else if (w_out_only) begin
      r_state <= S_OUT;
      r_hold  <= HOLD_W'(HOLD_CYC - 1);
    end else if (r_state != S_IDLE) begin
      if (r_hold == {HOLD_W{1'b0}}) begin
        r_state <= S_IDLE;
        r_hold  <= r_hold;
      end else begin
        r_state <= r_state;
        r_hold  <= r_hold - HOLD_W'(1);
      end
    end else begin
      r_state <= r_state;
      r_hold  <= r_hold;
    end
  end

`ifdef BLINK_FULL_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_phase_on;

  // Blink half-period counter; only runs while full, parked ON otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= {BLK_W{1'b0}};
      r_phase_on  <= 1'b1;
    end else if (!w_full) begin
      r_blink_cnt <= {BLK_W{1'b0}};
      r_phase_on  <= 1'b1;
    end else if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= {BLK_W{1'b0}};
      r_phase_on  <= ~r_phase_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      r_phase_on  <= r_phase_on;
    end
  end

  // Gated by the live full flag so the display is steady the first cycle
  // after the lot stops being full, without waiting for the phase reset.
  assign w_blank = w_full & ~r_phase_on;
`else
  assign w_blank = 1'b0;
`endif

  // Select the pattern for the digit currently being scanned.
  always_comb begin
    w_an_next = ~(4'b0001 << r_idx);
    w_dp_next = 1'b1;
    case (r_idx)
      2'd0: begin
        w_seg_next = seg7(w_d0);
        w_dp_next  = ~w_full;
      end
      2'd1: w_seg_next = seg7(w_d1);
      2'd2: w_seg_next = SEG_DASH;
      2'd3: begin
        case (r_state)
          S_IN:    w_seg_next = SEG_E;
          S_OUT:   w_seg_next = SEG_S;
          default: w_seg_next = SEG_BLANK;
        endcase
      end
      default: w_seg_next = SEG_BLANK;
    endcase
  end

  // Registered display outputs (one cycle behind the scan index).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else if (w_blank) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= w_seg_next;
      an  <= w_an_next;
      dp  <= w_dp_next;
    end
  end

endmodule

// File: tb/tb_display_ocupacion.sv
`timescale 1ns/1ps

module tb_display_ocupacion;

  logic       clk;
  logic       rst;
  logic [2:0] count;
  logic       ingreso;
  logic       egreso;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  display_ocupacion #(
    .CNT_W(3), .CAPACITY(7), .REFRESH_DIV(4), .HOLD_CYC(20), .BLINK_DIV(8)
  ) dut (
    .clk(clk), .rst(rst), .count(count), .ingreso(ingreso), .egreso(egreso),
    .seg(seg), .an(an), .dp(dp)
  );

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   k = 0;          // active (non-reset) clock edges seen
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!rst) k <= k + 1;
  end

  // Monitor: compare the DUT output against every expectation tagged for this edge.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == k) begin
        n_checks++;
        if (an !== sb_q[i].an || seg !== sb_q[i].seg || dp !== sb_q[i].dp) begin
          n_errors++;
          $display("FAIL %s @cyc %0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   sb_q[i].name, k, an, seg, dp, sb_q[i].an, sb_q[i].seg, sb_q[i].dp);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic push(input int c, input logic [3:0] a, input logic [6:0] s,
                      input logic d, input string nm);
    exp_t e;
    e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.name = nm;
    sb_q.push_back(e);
  endtask

  // Block until the k-th active edge has happened (inputs then change on this negedge).
  task automatic wait_k(input int n);
    while (k < n) @(negedge clk);
  endtask

  initial begin
    #50000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", k);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    rst = 1'b1; count = 3'd3; ingreso = 1'b0; egreso = 1'b0;

    // Reset values and idle scan with count=3 (free=4)
    push(0,  4'hF, 7'h7F, 1'b1, "reset");
    push(1,  4'hE, 7'b0110000, 1'b1, "d0_first");
    push(4,  4'hE, 7'b0110000, 1'b1, "d0_last");
    push(5,  4'hD, 7'b0011001, 1'b1, "d1_free4");
    push(9,  4'hB, 7'b0111111, 1'b1, "d2_dash");
    push(13, 4'h7, 7'h7F, 1'b1, "d3_idle");
    push(16, 4'h7, 7'h7F, 1'b1, "d3_idle_end");
    push(17, 4'hE, 7'b0110000, 1'b1, "d0_wrap");
    push(29, 4'h7, 7'h7F, 1'b1, "d3_idle2");
    // Ingreso at edge 42: 'E' on outputs 43..62, blank from 63
    push(45, 4'h7, 7'b0000110, 1'b1, "ev_in");
    push(61, 4'h7, 7'b0000110, 1'b1, "ev_in_late");
    push(62, 4'h7, 7'b0000110, 1'b1, "ev_in_last");
    push(63, 4'h7, 7'h7F, 1'b1, "ev_in_expired");
    push(64, 4'h7, 7'h7F, 1'b1, "ev_in_expired2");
    // Ingreso at 70, egreso at 80: 'S' retriggers, held through 100
    push(80, 4'h7, 7'b0000110, 1'b1, "ev_in_before_out");
    push(93, 4'h7, 7'b0010010, 1'b1, "ev_out");
    push(96, 4'h7, 7'b0010010, 1'b1, "ev_out_hold");
    push(109, 4'h7, 7'h7F, 1'b1, "ev_out_expired");
    // Both pulses while idle at 115: stays blank
    push(125, 4'h7, 7'h7F, 1'b1, "both_idle");
    // Ingreso at 130, both at 140 (no reload): blank by 151
    push(141, 4'h7, 7'b0000110, 1'b1, "both_show_keep");
    push(144, 4'h7, 7'b0000110, 1'b1, "both_show_keep2");
    push(157, 4'h7, 7'h7F, 1'b1, "both_no_reload");
    // Ingreso at 170, egreso exactly on expiry edge 190
    push(189, 4'h7, 7'b0000110, 1'b1, "expiry_in");
    push(190, 4'h7, 7'b0000110, 1'b1, "expiry_in_last");
    push(191, 4'h7, 7'b0010010, 1'b1, "expiry_pulse_wins");
    push(192, 4'h7, 7'b0010010, 1'b1, "expiry_pulse_wins2");
    push(205, 4'h7, 7'b0010010, 1'b1, "expiry_out_hold");
    push(221, 4'h7, 7'h7F, 1'b1, "expiry_out_done");

    repeat (3) @(negedge clk);
    n_checks++;
    if (an !== 4'hF) begin
      n_errors++;
      $display("FAIL reset_an: got an=%b, want 1111", an);
    end
    n_checks++;
    if (seg !== 7'h7F) begin
      n_errors++;
      $display("FAIL reset_seg: got seg=%b, want 1111111", seg);
    end
    n_checks++;
    if (dp !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_dp: got dp=%b, want 1", dp);
    end
    rst = 1'b0;

    wait_k(41); ingreso = 1'b1;
    wait_k(42); ingreso = 1'b0;
    wait_k(69); ingreso = 1'b1;
    wait_k(70); ingreso = 1'b0;
    wait_k(79); egreso = 1'b1;
    wait_k(80); egreso = 1'b0;
    wait_k(114); ingreso = 1'b1; egreso = 1'b1;
    wait_k(115); ingreso = 1'b0; egreso = 1'b0;
    wait_k(129); ingreso = 1'b1;
    wait_k(130); ingreso = 1'b0;
    wait_k(139); ingreso = 1'b1; egreso = 1'b1;
    wait_k(140); ingreso = 1'b0; egreso = 1'b0;
    wait_k(169); ingreso = 1'b1;
    wait_k(170); ingreso = 1'b0;
    wait_k(189); egreso = 1'b1;
    wait_k(190); egreso = 1'b0;

    // Full lot: count=7 from edge 235, drops to 6 at edge 290
    for (int c = 236; c <= 300; c++) begin
      int   slot;
      logic blank;
      slot  = ((c - 1) / 4) % 4;
      blank = 1'b0;
`ifdef BLINK_FULL_EN
      if (c <= 289 && c >= 243 && (((c - 243) / 8) % 2) == 0) blank = 1'b1;
`endif
      if (blank) begin
        push(c, 4'hF, 7'h7F, 1'b1, "blink_off");
      end else if (c <= 289) begin
        case (slot)
          0:       push(c, 4'hE, 7'b1111000, 1'b0, "full_d0_dp");
          1:       push(c, 4'hD, 7'b1000000, 1'b1, "full_d1_zero");
          2:       push(c, 4'hB, 7'b0111111, 1'b1, "full_d2");
          default: push(c, 4'h7, 7'h7F, 1'b1, "full_d3");
        endcase
      end else begin
        case (slot)
          0:       push(c, 4'hE, 7'b0000010, 1'b1, "notfull_d0");
          1:       push(c, 4'hD, 7'b1111001, 1'b1, "notfull_d1");
          2:       push(c, 4'hB, 7'b0111111, 1'b1, "notfull_d2");
          default: push(c, 4'h7, 7'h7F, 1'b1, "notfull_d3");
        endcase
      end
    end
    wait_k(234); count = 3'd7;
    wait_k(289); count = 3'd6;

    // Reset asserted during SHOW_IN; scan and FSM restart from scratch
    push(311, 4'hE, 7'b0000010, 1'b1, "post_rst_d0");
    push(315, 4'hD, 7'b1111001, 1'b1, "post_rst_d1");
    push(323, 4'h7, 7'h7F, 1'b1, "post_rst_d3_idle");
    wait_k(304); ingreso = 1'b1;
    wait_k(305); ingreso = 1'b0;
    wait_k(310); rst = 1'b1;
    repeat (2) @(negedge clk);
    push(310, 4'hF, 7'h7F, 1'b1, "mid_reset");
    repeat (2) @(negedge clk);
    n_checks++;
    if (an !== 4'hF) begin
      n_errors++;
      $display("FAIL mid_reset_an: got an=%b, want 1111", an);
    end
    n_checks++;
    if (seg !== 7'h7F) begin
      n_errors++;
      $display("FAIL mid_reset_seg: got seg=%b, want 1111111", seg);
    end
    n_checks++;
    if (dp !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset_dp: got dp=%b, want 1", dp);
    end
    rst = 1'b0;

    wait_k(330);
    @(negedge clk);
    foreach (sb_q[i]) begin
      n_errors++;
      $display("FAIL %s: expectation for cyc %0d never checked (now %0d)",
               sb_q[i].name, sb_q[i].cyc, k);
    end
    if (n_checks < 12) begin
      n_errors++;
      $display("FAIL too_few_checks: only %0d checks performed", n_checks);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
